// File: rtl/dram_read_arbiter_if.sv
// dram_read_arbiter_if: per-engine read request/data lanes plus the shared AXI read port
interface dram_read_arbiter_if #(
  parameter int NUM_PORTS       = 4,
  parameter int MAX_OUTSTANDING = 8
);
  logic [6*NUM_PORTS-1:0]            req_rd_id_in;
  logic [32*NUM_PORTS-1:0]           req_rd_addr_in;
  logic [8*NUM_PORTS-1:0]            req_rd_len_in;
  logic [NUM_PORTS-1:0]              req_rd_info_valid_in;
  logic [NUM_PORTS-1:0]              req_rd_info_rdy_out;
  logic [255:0]                      req_rd_data_out;
  logic [NUM_PORTS-1:0]              req_rd_data_valid_out;
  logic [NUM_PORTS-1:0]              req_rd_data_rdy_in;
  logic [5:0]                        rd_id_out;
  logic [31:0]                       rd_addr_out;
  logic [7:0]                        rd_len_out;
  logic                              rd_info_valid_out;
  logic                              rd_info_rdy_in;
  logic [255:0]                      rd_data_in;
  logic                              rd_data_valid_in;
  logic                              rd_data_rdy_out;
  logic [$clog2(MAX_OUTSTANDING):0]  outstanding_cnt_out;
  modport master (
    input  req_rd_id_in, req_rd_addr_in, req_rd_len_in, req_rd_info_valid_in, req_rd_data_rdy_in,
           rd_info_rdy_in, rd_data_in, rd_data_valid_in,
    output req_rd_info_rdy_out, req_rd_data_out, req_rd_data_valid_out,
           rd_id_out, rd_addr_out, rd_len_out, rd_info_valid_out, rd_data_rdy_out, outstanding_cnt_out
  );
  modport slave (
    output req_rd_id_in, req_rd_addr_in, req_rd_len_in, req_rd_info_valid_in, req_rd_data_rdy_in,
           rd_info_rdy_in, rd_data_in, rd_data_valid_in,
    input  req_rd_info_rdy_out, req_rd_data_out, req_rd_data_valid_out,
           rd_id_out, rd_addr_out, rd_len_out, rd_info_valid_out, rd_data_rdy_out, outstanding_cnt_out
  );
endinterface

// File: rtl/dram_read_arbiter.sv
// dram_read_arbiter: round-robin sharing of one AXI read port with in-order data steering
module dram_read_arbiter #(
  parameter int NUM_PORTS       = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input logic clk,
  input logic rst,
  dram_read_arbiter_if.master bus
);
  localparam int PW = $clog2(NUM_PORTS);
  localparam int AW = $clog2(MAX_OUTSTANDING);
  typedef enum logic {IDLE, ISSUE} state_t;
  state_t state;
  logic [PW-1:0] grant, last_grant, win, idx, head_port;
  logic found, empty, full, push, pop, beat;
  logic [PW-1:0] port_q [MAX_OUTSTANDING];
  logic [7:0] len_q [MAX_OUTSTANDING];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] cnt;
  logic [7:0] beat_cnt, head_len;
  assign empty = cnt == '0;
  assign full = cnt == (AW+1)'(MAX_OUTSTANDING);
  assign head_port = port_q[rd_ptr];
  assign head_len = len_q[rd_ptr];
  assign push = state == ISSUE && bus.rd_info_rdy_in;
  assign beat = bus.rd_data_valid_in && bus.rd_data_rdy_out;
  assign pop = beat && beat_cnt == head_len;
  assign bus.rd_data_rdy_out = !empty && bus.req_rd_data_rdy_in[head_port];
  assign bus.req_rd_data_out = bus.rd_data_in;
  assign bus.outstanding_cnt_out = cnt;
  // Round-robin pick: first valid port after the last granted one
  always_comb begin
    found = 1'b0;
    win = '0;
    idx = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      idx = PW'((int'(last_grant) + i) % NUM_PORTS);
      if (!found && bus.req_rd_info_valid_in[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
  end
  // Steer accept pulse and data valid to the owning requester only
  always_comb begin
    bus.req_rd_info_rdy_out = '0;
    bus.req_rd_info_rdy_out[grant] = push;
    bus.req_rd_data_valid_out = '0;
    bus.req_rd_data_valid_out[head_port] = bus.rd_data_valid_in && !empty;
  end
  // Address FSM, outstanding-burst FIFO and beat counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      grant <= '0;
      last_grant <= PW'(NUM_PORTS - 1);
      bus.rd_info_valid_out <= 1'b0;
      bus.rd_id_out <= '0;
      bus.rd_addr_out <= '0;
      bus.rd_len_out <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      beat_cnt <= '0;
    end else begin
      if (state == IDLE) begin
        if (found && !full) begin
          state <= ISSUE;
          grant <= win;
          bus.rd_info_valid_out <= 1'b1;
          bus.rd_id_out <= bus.req_rd_id_in[int'(win)*6 +: 6];
          bus.rd_addr_out <= bus.req_rd_addr_in[int'(win)*32 +: 32];
          bus.rd_len_out <= bus.req_rd_len_in[int'(win)*8 +: 8];
        end
      end else if (push) begin
        state <= IDLE;
        bus.rd_info_valid_out <= 1'b0;
        last_grant <= grant;
        port_q[wr_ptr] <= grant;
        len_q[wr_ptr] <= bus.rd_len_out;
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (beat) beat_cnt <= pop ? '0 : beat_cnt + 8'd1;
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: tb/tb_dram_read_arbiter.sv
// tb_dram_read_arbiter: randomized scenarios checked against a burst-queue reference model
module tb_dram_read_arbiter;
  localparam int NP = 4;
  localparam int MO = 8;
  typedef struct {int port; int len;} burst_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  burst_t q[$];
  int beat_m, last_g, checks, errors;
  logic [255:0] cur;
  always #5 clk = ~clk;
  dram_read_arbiter_if #(.NUM_PORTS(NP), .MAX_OUTSTANDING(MO)) bus();
  dram_read_arbiter #(.NUM_PORTS(NP), .MAX_OUTSTANDING(MO)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic set_req(input int p, input int len);
    bus.req_rd_id_in[6*p +: 6] = 6'($urandom);
    bus.req_rd_addr_in[32*p +: 32] = $urandom & 32'hFFFF_FFC0;
    bus.req_rd_len_in[8*p +: 8] = (len < 0) ? 8'($urandom_range(0, 3)) : 8'(len);
    bus.req_rd_info_valid_in[p] = 1'b1;
  endtask

  function automatic int rr_pick();
    for (int i = 1; i <= NP; i++)
      if (bus.req_rd_info_valid_in[(last_g + i) % NP]) return (last_g + i) % NP;
    return -1;
  endfunction

  function automatic void model_reset();
    q.delete();
    beat_m = 0;
    last_g = NP - 1;
  endfunction

  task automatic step(input int hs, input logic dv, input logic [NP-1:0] prdy);
    logic [NP-1:0] ev, eh;
    logic er, acc;
    bus.rd_info_rdy_in = hs >= 0;
    bus.rd_data_valid_in = dv;
    bus.req_rd_data_rdy_in = prdy;
    bus.rd_data_in = cur;
    #1;
    ev = '0;
    er = 1'b0;
    if (q.size() > 0) begin
      if (dv) ev = NP'(1) << q[0].port;
      er = prdy[q[0].port];
    end
    eh = (hs >= 0) ? NP'(1) << hs : '0;
    checks++;
    if (bus.req_rd_data_valid_out !== ev) begin errors++; $display("FAIL data_valid: got %b expected %b", bus.req_rd_data_valid_out, ev); end
    checks++;
    if (bus.rd_data_rdy_out !== er) begin errors++; $display("FAIL rd_data_rdy: got %b expected %b", bus.rd_data_rdy_out, er); end
    checks++;
    if (bus.req_rd_data_out !== cur) begin errors++; $display("FAIL data_out: got %h expected %h", bus.req_rd_data_out[31:0], cur[31:0]); end
    checks++;
    if (bus.req_rd_info_rdy_out !== eh) begin errors++; $display("FAIL info_rdy: got %b expected %b", bus.req_rd_info_rdy_out, eh); end
    if (hs >= 0) begin
      checks++;
      if (bus.rd_info_valid_out !== 1'b1) begin errors++; $display("FAIL handshake_valid: got %b expected 1", bus.rd_info_valid_out); end
    end
    acc = dv && er;
    @(posedge clk);
    #1;
    if (acc) begin
      beat_m++;
      cur = {8{$urandom}};
      if (beat_m > q[0].len) begin
        void'(q.pop_front());
        beat_m = 0;
      end
    end
    if (hs >= 0) begin
      q.push_back('{hs, int'(bus.req_rd_len_in[8*hs +: 8])});
      last_g = hs;
    end
    checks++;
    if (int'(bus.outstanding_cnt_out) != q.size()) begin errors++; $display("FAIL outstanding: got %0d expected %0d", bus.outstanding_cnt_out, q.size()); end
  endtask

  task automatic wait_issue(input int w);
    int n = 0;
    while (bus.rd_info_valid_out !== 1'b1 && n < 10) begin
      step(-1, 1'b0, '1);
      n++;
    end
    checks++;
    if (bus.rd_info_valid_out !== 1'b1) begin errors++; $display("FAIL issue_timeout: got %b expected 1", bus.rd_info_valid_out); end
    checks++;
    if ({bus.rd_id_out, bus.rd_addr_out, bus.rd_len_out} !==
        {bus.req_rd_id_in[6*w +: 6], bus.req_rd_addr_in[32*w +: 32], bus.req_rd_len_in[8*w +: 8]}) begin
      errors++;
      $display("FAIL issue_fields: got id %h addr %h len %h expected port %0d id %h addr %h len %h",
               bus.rd_id_out, bus.rd_addr_out, bus.rd_len_out, w,
               bus.req_rd_id_in[6*w +: 6], bus.req_rd_addr_in[32*w +: 32], bus.req_rd_len_in[8*w +: 8]);
    end
  endtask

  task automatic issue();
    int w = rr_pick();
    wait_issue(w);
    step(w, 1'b0, '1);
    bus.req_rd_info_valid_in[w] = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 500) begin
      logic [NP-1:0] pr;
      pr = NP'($urandom);
      if ($urandom_range(0, 1) == 1) pr[q[0].port] = 1'b1;
      step(-1, $urandom_range(0, 3) != 0, pr);
      n++;
    end
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL drain_timeout: got %0d left expected 0", q.size()); end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.req_rd_info_valid_in = '1;
    bus.rd_info_rdy_in = 1'b1;
    bus.rd_data_valid_in = 1'b1;
    bus.req_rd_data_rdy_in = '1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.rd_info_valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.rd_info_valid_out); end
    checks++;
    if (bus.req_rd_info_rdy_out !== '0) begin errors++; $display("FAIL reset_info_rdy: got %b expected 0", bus.req_rd_info_rdy_out); end
    checks++;
    if (bus.outstanding_cnt_out !== '0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", bus.outstanding_cnt_out); end
    checks++;
    if (bus.rd_data_rdy_out !== 1'b0 || bus.req_rd_data_valid_out !== '0) begin errors++; $display("FAIL reset_data: got rdy %b valid %b expected 0", bus.rd_data_rdy_out, bus.req_rd_data_valid_out); end
    checks++;
    if ({bus.rd_id_out, bus.rd_addr_out, bus.rd_len_out} !== '0) begin errors++; $display("FAIL reset_fields: got addr %h expected 0", bus.rd_addr_out); end
    rst = 1'b1;
    bus.req_rd_info_valid_in = '0;
    bus.rd_info_rdy_in = 1'b0;
    bus.rd_data_valid_in = 1'b0;
    model_reset();
  endtask

  task automatic test_single();
    set_req(2, 3);
    bus.req_rd_addr_in[95:64] = 32'h1000;
    checks++;
    if (bus.rd_info_valid_out !== 1'b0) begin errors++; $display("FAIL single_pre_valid: got %b expected 0", bus.rd_info_valid_out); end
    step(-1, 1'b0, '1);
    checks++;
    if (bus.rd_info_valid_out !== 1'b1 || bus.rd_addr_out !== 32'h1000) begin errors++; $display("FAIL single_latency: got valid %b addr %h expected 1 1000", bus.rd_info_valid_out, bus.rd_addr_out); end
    wait_issue(2);
    step(2, 1'b0, '1);
    bus.req_rd_info_valid_in[2] = 1'b0;
    repeat (4) step(-1, 1'b1, '1);
    checks++;
    if (bus.outstanding_cnt_out !== '0) begin errors++; $display("FAIL single_done_cnt: got %0d expected 0", bus.outstanding_cnt_out); end
    step(-1, 1'b1, '1);
  endtask

  task automatic test_round_robin();
    test_reset();
    for (int p = 0; p < NP; p++) set_req(p, -1);
    for (int k = 0; k < MO; k++) begin
      wait_issue(k % NP);
      step(k % NP, 1'b0, '1);
      set_req(k % NP, -1);
    end
    repeat (3) begin
      step(-1, 1'b0, '1);
      checks++;
      if (bus.rd_info_valid_out !== 1'b0) begin errors++; $display("FAIL rr_full_valid: got %b expected 0", bus.rd_info_valid_out); end
    end
    bus.req_rd_info_valid_in = '0;
    drain();
  endtask

  task automatic test_full();
    int p9, p10, n;
    for (int k = 0; k < MO; k++) begin
      set_req($urandom_range(0, NP - 1), -1);
      issue();
    end
    p9 = $urandom_range(0, NP - 1);
    set_req(p9, -1);
    repeat (4) begin
      step(-1, 1'b0, '1);
      checks++;
      if (bus.rd_info_valid_out !== 1'b0) begin errors++; $display("FAIL full_no_issue: got %b expected 0", bus.rd_info_valid_out); end
    end
    n = 0;
    while (q.size() == MO && n < 20) begin step(-1, 1'b1, '1); n++; end
    wait_issue(p9);
    step(p9, 1'b0, '1);
    bus.req_rd_info_valid_in[p9] = 1'b0;
    checks++;
    if (int'(bus.outstanding_cnt_out) != MO) begin errors++; $display("FAIL full_refill: got %0d expected %0d", bus.outstanding_cnt_out, MO); end
    p10 = $urandom_range(0, NP - 1);
    set_req(p10, -1);
    n = 0;
    while (q.size() == MO && n < 20) begin step(-1, 1'b1, '1); n++; end
    wait_issue(p10);
    while (beat_m < q[0].len) step(-1, 1'b1, '1);
    step(p10, 1'b1, '1);
    bus.req_rd_info_valid_in[p10] = 1'b0;
    checks++;
    if (int'(bus.outstanding_cnt_out) != MO - 1) begin errors++; $display("FAIL push_pop_cnt: got %0d expected %0d", bus.outstanding_cnt_out, MO - 1); end
    drain();
  endtask

  task automatic test_backpressure();
    int p = $urandom_range(0, NP - 1);
    set_req(p, 7);
    issue();
    repeat (3) step(-1, 1'b1, '1);
    repeat (5) step(-1, 1'b1, ~(NP'(1) << p));
    checks++;
    if (bus.outstanding_cnt_out !== 1) begin errors++; $display("FAIL bp_cnt: got %0d expected 1", bus.outstanding_cnt_out); end
    while (q.size() > 0) step(-1, 1'b1, '1);
  endtask

  task automatic test_mid_reset();
    for (int k = 0; k < 3; k++) begin
      set_req($urandom_range(0, NP - 1), -1);
      issue();
    end
    set_req($urandom_range(0, NP - 1), -1);
    wait_issue(rr_pick());
    rst = 1'b0;
    bus.rd_data_valid_in = 1'b1;
    bus.req_rd_data_rdy_in = '1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.req_rd_info_valid_in = '0;
    model_reset();
    checks++;
    if (bus.rd_info_valid_out !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", bus.rd_info_valid_out); end
    checks++;
    if (bus.outstanding_cnt_out !== '0) begin errors++; $display("FAIL midrst_cnt: got %0d expected 0", bus.outstanding_cnt_out); end
    checks++;
    if (bus.rd_data_rdy_out !== 1'b0) begin errors++; $display("FAIL midrst_rdy: got %b expected 0", bus.rd_data_rdy_out); end
    set_req(1, -1);
    set_req(0, -1);
    wait_issue(0);
    step(0, 1'b0, '1);
    bus.req_rd_info_valid_in[0] = 1'b0;
    issue();
    drain();
  endtask

  task automatic test_random();
    repeat (8) begin
      logic [NP-1:0] m;
      m = NP'($urandom_range(1, (1 << NP) - 1));
      for (int p = 0; p < NP; p++) if (m[p]) set_req(p, -1);
      while (bus.req_rd_info_valid_in != '0) issue();
      drain();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    cur = '0;
    bus.req_rd_id_in = '0;
    bus.req_rd_addr_in = '0;
    bus.req_rd_len_in = '0;
    bus.req_rd_info_valid_in = '0;
    bus.req_rd_data_rdy_in = '0;
    bus.rd_info_rdy_in = 1'b0;
    bus.rd_data_in = '0;
    bus.rd_data_valid_in = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_round_robin();
    test_full();
    test_backpressure();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
